// File: rtl/neopixel_pkg.sv
// Shared NeoPixel (WS2812) definitions: pixel word type, FSM state encoding
// and the 50 MHz timing constants used by both the receiver and transmitter.
package neopixel_pkg;

    localparam int unsigned PIXEL_W  = 24;
    localparam int unsigned INDEX_W  = 16;
    localparam int unsigned BITCNT_W = 5;

    // GRB word, first bit on the wire in bit 23
    typedef logic [PIXEL_W-1:0] pixel_t;

    // Nominal WS2812 waveform at 50 MHz (transmitter side)
    localparam int unsigned CLK_FREQ_HZ_50M = 50_000_000;
    localparam int unsigned T0H_CYC_50M     = 20;
    localparam int unsigned T0L_CYC_50M     = 43;
    localparam int unsigned T1H_CYC_50M     = 40;
    localparam int unsigned T1L_CYC_50M     = 22;

    // Receiver decode windows at 50 MHz
    localparam int unsigned MIN_HIGH_CYC_50M   = 10;
    localparam int unsigned BIT_THRESH_CYC_50M = 28;
    localparam int unsigned MAX_HIGH_CYC_50M   = 60;
    localparam int unsigned LATCH_CYC_50M      = 2500;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } rx_state_e;

    // Saturating pixel index increment
    function automatic logic [INDEX_W-1:0] index_inc(input logic [INDEX_W-1:0] idx);
        return (idx == '1) ? idx : idx + INDEX_W'(1);
    endfunction

endpackage

// File: rtl/neopixel_sync.sv
// Two-flop synchronizer for the asynchronous one-wire input, followed by a
// registered copy of the synchronized level and registered edge pulses.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   din        : asynchronous serial input
//   line       : synchronized level (aligned with rise/fall)
//   rise, fall : one-cycle pulses on synchronized rising/falling edges
module neopixel_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic line,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;

    // line is the previous value of sync_q, so edges compare the two
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            line   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= din;
            sync_q <= meta;
            line   <= sync_q;
            rise   <= sync_q & ~line;
            fall   <= ~sync_q & line;
        end
    end

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 one-wire receiver. Measures high-pulse widths to decode bits,
// assembles 24-bit GRB words MSB-first and presents them on a valid/ready
// port with a per-frame index. A long low time is a latch (end of frame).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   neopixel_one_wire   : asynchronous serial data in
//   pixel_data          : decoded word
//   pixel_valid         : pixel_data holds an unconsumed word
//   pixel_ready         : consumer accepts the word
//   pixel_index         : index of pixel_data within its frame
//   frame_done          : one-cycle pulse on latch detection
//   overrun             : sticky, a decoded word was dropped
//   bit_err             : sticky, glitch or over-long high pulse seen
module neopixel_rx
    import neopixel_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = CLK_FREQ_HZ_50M,
    parameter int unsigned MIN_HIGH_CYC   = MIN_HIGH_CYC_50M,
    parameter int unsigned BIT_THRESH_CYC = BIT_THRESH_CYC_50M,
    parameter int unsigned MAX_HIGH_CYC   = MAX_HIGH_CYC_50M,
    parameter int unsigned LATCH_CYC      = LATCH_CYC_50M
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               neopixel_one_wire,
    output logic [PIXEL_W-1:0] pixel_data,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic [INDEX_W-1:0] pixel_index,
    output logic               frame_done,
    output logic               overrun,
    output logic               bit_err
);

    localparam int unsigned LCW = $clog2(LATCH_CYC + 1);
    localparam int unsigned HCW = $clog2(MAX_HIGH_CYC + 2);

    localparam logic [LCW-1:0] LATCH_MAX  = LCW'(LATCH_CYC);
    localparam logic [LCW-1:0] LATCH_LAST = LCW'(LATCH_CYC - 1);

    // hcnt holds (pulse length - 1) when the falling edge is seen
    localparam logic [HCW-1:0] HIGH_SAT = HCW'(MAX_HIGH_CYC + 1);
    localparam logic [HCW-1:0] HIGH_MIN = HCW'(MIN_HIGH_CYC - 1);
    localparam logic [HCW-1:0] HIGH_ONE = HCW'(BIT_THRESH_CYC - 1);
    localparam logic [HCW-1:0] HIGH_MAX = HCW'(MAX_HIGH_CYC);

    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(PIXEL_W - 1);

    // Parameter sanity: windows ordered, latch at least 50 us
    if (MIN_HIGH_CYC == 0 || MIN_HIGH_CYC > BIT_THRESH_CYC ||
        BIT_THRESH_CYC > MAX_HIGH_CYC) begin : g_bad_window
        $error("neopixel_rx: high-pulse windows out of order");
    end
    if (LATCH_CYC < CLK_FREQ_HZ / 20_000) begin : g_bad_latch
        $error("neopixel_rx: LATCH_CYC shorter than 50 us");
    end

    logic line;
    logic rise;
    logic fall;

    neopixel_sync u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (neopixel_one_wire),
        .line (line),
        .rise (rise),
        .fall (fall)
    );

    rx_state_e          state,       state_n;
    logic [LCW-1:0]     lcnt,        lcnt_n;
    logic [HCW-1:0]     hcnt,        hcnt_n;
    pixel_t             shreg,       shreg_n;
    logic [BITCNT_W-1:0] bitcnt,     bitcnt_n;
    logic               word_done,   word_done_n;
    logic [INDEX_W-1:0] word_cnt,    word_cnt_n;
    pixel_t             data_n;
    logic               valid_n;
    logic [INDEX_W-1:0] index_n;
    logic               frame_done_n;
    logic               overrun_n;
    logic               bit_err_n;
    logic               frame_clr;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC;
            lcnt        <= '0;
            hcnt        <= '0;
            shreg       <= '0;
            bitcnt      <= '0;
            word_done   <= 1'b0;
            word_cnt    <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            bit_err     <= 1'b0;
        end else begin
            state       <= state_n;
            lcnt        <= lcnt_n;
            hcnt        <= hcnt_n;
            shreg       <= shreg_n;
            bitcnt      <= bitcnt_n;
            word_done   <= word_done_n;
            word_cnt    <= word_cnt_n;
            pixel_data  <= data_n;
            pixel_valid <= valid_n;
            pixel_index <= index_n;
            frame_done  <= frame_done_n;
            overrun     <= overrun_n;
            bit_err     <= bit_err_n;
        end
    end

    // Next-state, decode and handshake logic
    always_comb begin
        state_n      = state;
        lcnt_n       = lcnt;
        hcnt_n       = hcnt;
        shreg_n      = shreg;
        bitcnt_n     = bitcnt;
        word_done_n  = 1'b0;
        word_cnt_n   = word_cnt;
        data_n       = pixel_data;
        valid_n      = pixel_valid;
        index_n      = pixel_index;
        frame_done_n = 1'b0;
        overrun_n    = overrun;
        bit_err_n    = bit_err;
        frame_clr    = 1'b0;

        unique case (state)
            // Ignore the wire until one full latch of low time
            SYNC: begin
                if (line) begin
                    lcnt_n = '0;
                end else if (lcnt >= LATCH_LAST) begin
                    state_n   = LOW;
                    lcnt_n    = LATCH_MAX;
                    frame_clr = 1'b1;
                end else begin
                    lcnt_n = lcnt + LCW'(1);
                end
            end

            LOW: begin
                if (rise) begin
                    state_n = HIGH;
                    hcnt_n  = '0;
                end else if (lcnt != LATCH_MAX) begin
                    lcnt_n = lcnt + LCW'(1);
                    if (lcnt == LATCH_LAST) begin
                        frame_done_n = 1'b1;
                        frame_clr    = 1'b1;
                    end
                end
            end

            HIGH: begin
                if (fall) begin
                    // The falling-edge cycle is the first low cycle
                    lcnt_n = LCW'(1);
                    if (hcnt < HIGH_MIN || hcnt >= HIGH_MAX) begin
                        bit_err_n = 1'b1;
                        state_n   = SYNC;
                        shreg_n   = '0;
                        bitcnt_n  = '0;
                    end else begin
                        state_n = LOW;
                        shreg_n = {shreg[PIXEL_W-2:0], (hcnt >= HIGH_ONE)};
                        if (bitcnt == LAST_BIT) begin
                            bitcnt_n    = '0;
                            word_done_n = 1'b1;
                        end else begin
                            bitcnt_n = bitcnt + BITCNT_W'(1);
                        end
                    end
                end else if (hcnt != HIGH_SAT) begin
                    hcnt_n = hcnt + HCW'(1);
                end
            end

            default: state_n = SYNC;
        endcase

        if (pixel_valid && pixel_ready) begin
            valid_n = 1'b0;
        end

        // A completed word loads unless an unconsumed one is still held
        if (word_done) begin
            if (!pixel_valid || pixel_ready) begin
                data_n  = shreg;
                valid_n = 1'b1;
                index_n = word_cnt;
            end else begin
                overrun_n = 1'b1;
            end
            word_cnt_n = index_inc(word_cnt);
        end

        if (frame_clr) begin
            shreg_n    = '0;
            bitcnt_n   = '0;
            word_cnt_n = '0;
        end

        // A held word keeps its own index across the latch
        if (frame_done_n && !valid_n) begin
            index_n = '0;
        end
    end

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: drives WS2812 waveforms and checks decoded
// words, indices, frame pulses, sticky flags and reset behaviour.
module tb_neopixel_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        wire_in;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [15:0] pixel_index;
    logic        frame_done;
    logic        overrun;
    logic        bit_err;

    int tests = 0;
    int fails = 0;

    logic [23:0] acc_data[$];
    logic [15:0] acc_idx[$];
    int          fd_cnt;
    int          vcyc;

    logic [23:0] got_d;
    logic [15:0] got_i;

    always #5 clk = ~clk;

    neopixel_rx dut (
        .clk              (clk),
        .reset            (reset),
        .neopixel_one_wire(wire_in),
        .pixel_data       (pixel_data),
        .pixel_valid      (pixel_valid),
        .pixel_ready      (pixel_ready),
        .pixel_index      (pixel_index),
        .frame_done       (frame_done),
        .overrun          (overrun),
        .bit_err          (bit_err)
    );

    // Record accepted words and frame pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (pixel_valid && pixel_ready) begin
                acc_data.push_back(pixel_data);
                acc_idx.push_back(pixel_index);
            end
            if (frame_done) fd_cnt++;
            if (pixel_valid) vcyc++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        wire_in = lvl;
        tick(n);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b1, 35);
            drive(1'b0, 30);
        end else begin
            drive(1'b1, 18);
            drive(1'b0, 42);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
    endtask

    task automatic clear_mon();
        acc_data.delete();
        acc_idx.delete();
        fd_cnt = 0;
        vcyc   = 0;
    endtask

    task automatic fetch(input int k);
        got_d = (acc_data.size() > k) ? acc_data[k] : 24'hFFFFFF;
        got_i = (acc_idx.size() > k) ? acc_idx[k] : 16'hFFFF;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wire_in = 1'b0;
        pixel_ready = 1'b1;
        tick(5);
        tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", pixel_valid); end
        tests++; if (pixel_data !== 24'h0) begin fails++; $display("FAIL reset_data: got %h want 000000", pixel_data); end
        tests++; if (pixel_index !== 16'h0) begin fails++; $display("FAIL reset_index: got %0d want 0", pixel_index); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
        tests++; if (bit_err !== 1'b0) begin fails++; $display("FAIL reset_bit_err: got %0b want 0", bit_err); end
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        drive(1'b0, 3000);
        clear_mon();
        send_word(24'hA5C30F);
        drive(1'b0, 10);
        tests++; if (acc_data.size() != 1) begin fails++; $display("FAIL single_count: got %0d want 1", acc_data.size()); end
        fetch(0);
        tests++; if (got_d !== 24'hA5C30F) begin fails++; $display("FAIL single_data: got %h want a5c30f", got_d); end
        tests++; if (got_i !== 16'd0) begin fails++; $display("FAIL single_index: got %0d want 0", got_i); end
        tests++; if (vcyc != 1) begin fails++; $display("FAIL single_valid_cycles: got %0d want 1", vcyc); end
        tests++; if (bit_err !== 1'b0) begin fails++; $display("FAIL single_bit_err: got %0b want 0", bit_err); end
    endtask

    task automatic test_frame();
        drive(1'b0, 2600);
        clear_mon();
        send_word(24'h112233);
        send_word(24'h445566);
        send_word(24'h778899);
        drive(1'b0, 2600);
        tests++; if (acc_data.size() != 3) begin fails++; $display("FAIL frame_count: got %0d want 3", acc_data.size()); end
        fetch(0);
        tests++; if (got_d !== 24'h112233 || got_i !== 16'd0) begin fails++; $display("FAIL frame_word0: got %h/%0d want 112233/0", got_d, got_i); end
        fetch(1);
        tests++; if (got_d !== 24'h445566 || got_i !== 16'd1) begin fails++; $display("FAIL frame_word1: got %h/%0d want 445566/1", got_d, got_i); end
        fetch(2);
        tests++; if (got_d !== 24'h778899 || got_i !== 16'd2) begin fails++; $display("FAIL frame_word2: got %h/%0d want 778899/2", got_d, got_i); end
        tests++; if (fd_cnt != 1) begin fails++; $display("FAIL frame_done_pulses: got %0d want 1", fd_cnt); end
        clear_mon();
        send_word(24'h00FF00);
        drive(1'b0, 10);
        fetch(0);
        tests++; if (got_d !== 24'h00FF00 || got_i !== 16'd0) begin fails++; $display("FAIL frame_next_word: got %h/%0d want 00ff00/0", got_d, got_i); end
    endtask

    task automatic test_overrun();
        drive(1'b0, 2600);
        clear_mon();
        pixel_ready = 1'b0;
        send_word(24'h123456);
        send_word(24'h654321);
        tests++; if (pixel_valid !== 1'b1) begin fails++; $display("FAIL ovr_held_valid: got %0b want 1", pixel_valid); end
        tests++; if (pixel_data !== 24'h123456) begin fails++; $display("FAIL ovr_held_data: got %h want 123456", pixel_data); end
        tests++; if (pixel_index !== 16'd0) begin fails++; $display("FAIL ovr_held_index: got %0d want 0", pixel_index); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
        pixel_ready = 1'b1;
        tick(1);
        pixel_ready = 1'b0;
        tick(2);
        tests++; if (acc_data.size() != 1) begin fails++; $display("FAIL ovr_accept_count: got %0d want 1", acc_data.size()); end
        tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL ovr_valid_drop: got %0b want 0", pixel_valid); end
        pixel_ready = 1'b1;
        send_word(24'hABCDEF);
        drive(1'b0, 10);
        fetch(1);
        tests++; if (got_d !== 24'hABCDEF || got_i !== 16'd2) begin fails++; $display("FAIL ovr_third_word: got %h/%0d want abcdef/2", got_d, got_i); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
    endtask

    task automatic test_glitch();
        drive(1'b0, 2600);
        clear_mon();
        tests++; if (bit_err !== 1'b0) begin fails++; $display("FAIL glitch_pre: got %0b want 0", bit_err); end
        send_bits(24'hF0F0F0, 8);
        drive(1'b1, 5);
        drive(1'b0, 40);
        send_word(24'h111111);
        drive(1'b0, 10);
        tests++; if (bit_err !== 1'b1) begin fails++; $display("FAIL glitch_bit_err: got %0b want 1", bit_err); end
        tests++; if (acc_data.size() != 0) begin fails++; $display("FAIL glitch_no_word: got %0d want 0", acc_data.size()); end
        drive(1'b0, 2600);
        send_word(24'hC0FFEE);
        drive(1'b0, 10);
        fetch(0);
        tests++; if (acc_data.size() != 1 || got_d !== 24'hC0FFEE || got_i !== 16'd0) begin fails++; $display("FAIL glitch_resume: got %0d words, %h/%0d want 1, c0ffee/0", acc_data.size(), got_d, got_i); end
        tests++; if (bit_err !== 1'b1) begin fails++; $display("FAIL glitch_sticky: got %0b want 1", bit_err); end
    endtask

    task automatic test_partial();
        clear_mon();
        send_bits(24'hFFF000, 12);
        drive(1'b0, 2600);
        tests++; if (fd_cnt != 1) begin fails++; $display("FAIL partial_frame_done: got %0d want 1", fd_cnt); end
        tests++; if (acc_data.size() != 0 || vcyc != 0) begin fails++; $display("FAIL partial_no_valid: got %0d words %0d valid cycles want 0", acc_data.size(), vcyc); end
        send_word(24'h5A5A5A);
        drive(1'b0, 10);
        fetch(0);
        tests++; if (got_d !== 24'h5A5A5A || got_i !== 16'd0) begin fails++; $display("FAIL partial_next_word: got %h/%0d want 5a5a5a/0", got_d, got_i); end
    endtask

    task automatic test_reset_mid();
        send_bits(24'h3C3C3C, 10);
        drive(1'b1, 10);
        reset = 1'b1;
        wire_in = 1'b0;
        tick(3);
        tests++; if (pixel_valid !== 1'b0 || pixel_data !== 24'h0 || pixel_index !== 16'h0) begin fails++; $display("FAIL rstmid_word: got %0b/%h/%0d want 0/000000/0", pixel_valid, pixel_data, pixel_index); end
        tests++; if (overrun !== 1'b0 || bit_err !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL rstmid_flags: got ovr %0b err %0b fd %0b want 0", overrun, bit_err, frame_done); end
        reset = 1'b0;
        clear_mon();
        send_bits(24'h3C3C3C, 14);
        send_word(24'h333333);
        drive(1'b0, 10);
        tests++; if (acc_data.size() != 0) begin fails++; $display("FAIL rstmid_no_decode: got %0d want 0", acc_data.size()); end
        drive(1'b0, 2600);
        send_word(24'h0F0F0F);
        drive(1'b0, 10);
        fetch(0);
        tests++; if (acc_data.size() != 1 || got_d !== 24'h0F0F0F || got_i !== 16'd0) begin fails++; $display("FAIL rstmid_resume: got %0d words, %h/%0d want 1, 0f0f0f/0", acc_data.size(), got_d, got_i); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single_word();
        test_frame();
        test_overrun();
        test_glitch();
        test_partial();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neopixel_rx.md
NEOPIXEL_RX -- requirements
Module: neopixel_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter MIN_HIGH_CYC, default 10: high pulses shorter than this are glitches.
REQ-003 SHALL have parameter BIT_THRESH_CYC, default 28: high pulse of at least this length decodes as 1, shorter decodes as 0.
REQ-004 SHALL have parameter MAX_HIGH_CYC, default 60: high pulses longer than this are errors.
REQ-005 SHALL have parameter LATCH_CYC, default 2500: low time of at least this length is a latch (50 us at 50 MHz).
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port neopixel_one_wire, input, 1: asynchronous WS2812 one-wire serial data.
REQ-009 SHALL have port pixel_data, output, 24: decoded GRB word, first-received bit in bit 23.
REQ-010 SHALL have port pixel_valid, output, 1: pixel_data holds an unconsumed word.
REQ-011 SHALL have port pixel_ready, input, 1: consumer accepts the word.
REQ-012 SHALL have port pixel_index, output, 16: position of pixel_data within the current frame, starting at 0.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse on latch detection.
REQ-014 SHALL have port overrun, output, 1: sticky flag, a decoded word was dropped.
REQ-015 SHALL have port bit_err, output, 1: sticky flag, a glitch or over-long high pulse occurred.

Function
REQ-016 SHALL pass neopixel_one_wire through a 2-flop synchronizer; all decoding uses the synchronized signal and its registered edge detection.
REQ-017 SHALL implement FSM states SYNC, LOW, HIGH; SYNC is entered on reset and discards all input until LATCH_CYC consecutive low cycles have been seen.
REQ-018 In SYNC, a rising edge before the latch count completes SHALL restart the low count without decoding anything.
REQ-019 LOW SHALL count low cycles (saturating at LATCH_CYC); a rising edge SHALL move to HIGH with the high counter cleared.
REQ-020 HIGH SHALL count high cycles (saturating at MAX_HIGH_CYC+1); a falling edge SHALL classify the pulse and move to LOW.
REQ-021 A high pulse with count < MIN_HIGH_CYC or > MAX_HIGH_CYC SHALL set bit_err, discard the partial word, and go to SYNC.
REQ-022 Valid bits SHALL be shifted MSB-first into a 24-bit shift register with a 5-bit bit counter.
REQ-023 On the 24th bit, if pixel_valid is low or pixel_ready is high, the word SHALL load pixel_data in the cycle after the synchronized falling edge, and pixel_valid SHALL assert.
REQ-024 On the 24th bit with pixel_valid high and pixel_ready low, the new word SHALL be dropped, overrun set, and pixel_index still advanced.
REQ-025 pixel_valid SHALL deassert the cycle after pixel_valid and pixel_ready are both high, unless a new word loads in that same cycle.
REQ-026 Low count reaching LATCH_CYC in LOW SHALL pulse frame_done once, clear the shift register, bit counter and pixel_index, and drop a partial word silently.
REQ-027 pixel_index SHALL saturate at 65535.
REQ-028 A held pixel_data/pixel_valid SHALL remain valid across frame_done.

Reset
REQ-029 Reset SHALL force: state SYNC, pixel_valid 0, pixel_data 0, pixel_index 0, frame_done 0, overrun 0, bit_err 0, all counters 0, synchronizer flops 0.
REQ-030 Reset asserted mid-word or mid-handshake SHALL discard everything; decoding resumes only after a fresh latch.
REQ-031 overrun and bit_err SHALL clear only on reset.

Structure
REQ-032 neopixel_pkg SHALL hold the pixel_t (24-bit GRB) typedef and the 50 MHz timing constants, shared with the transmitter.
REQ-033 A single sub-module, neopixel_sync (2-flop synchronizer plus rise/fall edge pulses), SHALL be instantiated; everything else is flat.

Verification
REQ-034 Sequence: 3000 low cycles, then 24 bits of 0xA5C30F (T0H=18/T0L=42, T1H=35/T1L=30 cycles), pixel_ready=1 -> pixel_data=0xA5C30F, pixel_valid for 1 cycle, pixel_index=0.
REQ-035 Sequence: 3 words then 2600 low cycles -> indices 0,1,2, then frame_done pulses exactly once and the next word has index 0.
REQ-036 Sequence: pixel_ready=0 while two words arrive -> first word held, overrun=1, pixel_index reads 0 until the first word is accepted.
REQ-037 Sequence: a 5-cycle high glitch mid-word -> bit_err=1, no word output, decoding resumes only after a 2500-cycle low.
REQ-038 Sequence: 12 bits then latch -> frame_done=1, no pixel_valid, next full word decoded correctly.
REQ-039 Sequence: reset asserted at bit 10 -> all outputs at reset values; no decoding until a latch is seen.
